i2c_display_target: RTL and testbench

//  I2C target (responder) for the OLED write stream produced by the screen I2C initiator.

---
 rtl/i2c_display_target_pkg.sv | 42 ++++
 rtl/i2c_display_target_if.sv | 24 ++
 rtl/i2c_display_target_line_sync.sv | 71 +++++++
 rtl/i2c_display_target.sv | 153 +++++++++++++++
 tb/tb_i2c_display_target.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_display_target_pkg.sv
// Shared types and constants for the SSD1306-style I2C display target.
// Optional glitch filter is selected with `I2C_GLITCH_FILTER_EN (see i2c_display_target_line_sync).
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CTRL,
        CTRL_ACK,
        BYTE,
        BYTE_ACK,
        IGNORE
    } i2c_state_e;

    localparam int CTRL_CO_BIT = 7;
    localparam int CTRL_DC_BIT = 6;

    localparam logic [7:0] CMD_PAGE_BASE  = 8'hB0;
    localparam logic [7:0] CMD_COLLO_BASE = 8'h00;
    localparam logic [7:0] CMD_COLHI_BASE = 8'h10;

    localparam int PAGE_W = 3;
    localparam int COL_W  = 7;
    localparam int PTR_W  = PAGE_W + COL_W;

    typedef struct packed {
        logic set_page;
        logic set_col_lo;
        logic set_col_hi;
    } cmd_dec_t;

    // Addressing commands carry their operand in the low bits; match on the fixed high bits.
    function automatic cmd_dec_t decode_cmd(input logic [7:0] c);
        cmd_dec_t d;
        d.set_page   = (c[7:3] == CMD_PAGE_BASE[7:3]);
        d.set_col_lo = (c[7:4] == CMD_COLLO_BASE[7:4]);
        d.set_col_hi = (c[7:3] == CMD_COLHI_BASE[7:3]);
        return d;
    endfunction

endpackage

// File: rtl/i2c_display_target_if.sv
// Bus/port bundle for i2c_display_target: pad side (SCL/SDA) plus framebuffer and command outputs.
interface i2c_display_target_if #(
    parameter int FB_AW = 10
);
    logic             scl_in;
    logic             sda_in;
    logic             sda_oe;
    logic             fb_wen;
    logic [FB_AW-1:0] fb_waddr;
    logic [7:0]       fb_wdata;
    logic             cmd_valid;
    logic [7:0]       cmd_byte;
    logic             busy;

    modport master (
        output scl_in, sda_in,
        input  sda_oe, fb_wen, fb_waddr, fb_wdata, cmd_valid, cmd_byte, busy
    );

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, fb_wen, fb_waddr, fb_wdata, cmd_valid, cmd_byte, busy
    );
endinterface

// File: rtl/i2c_display_target_line_sync.sv
// SCL/SDA synchronizers, optional glitch filter (`I2C_GLITCH_FILTER_EN), and edge/START/STOP detection.
module i2c_display_target_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    // [line][stage]: line 0 = SCL, line 1 = SDA. Idle bus level is high.
    logic [1:0][1:0] sync_q;
    logic [1:0]      line_s;
    logic [1:0]      line_f;
    logic [1:0]      line_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= {sync_q[0][0], scl_in};
            sync_q[1] <= {sync_q[1][0], sda_in};
        end
    end

    assign line_s = {sync_q[1][1], sync_q[0][1]};

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    // A line only changes once the new level has been seen FILTER_LEN samples in a row.
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic [CNT_W-1:0] cnt_q;
        logic             filt_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else if (line_s[i] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_q <= line_s[i];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign line_f[i] = filt_q;
    end
`else
    assign line_f = line_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) line_d <= '1;
        else        line_d <= line_f;
    end

    assign scl_rise  =  line_f[0] & ~line_d[0];
    assign scl_fall  = ~line_f[0] &  line_d[0];
    assign start_det =  line_f[0] &  line_d[0] &  line_d[1] & ~line_f[1];
    assign stop_det  =  line_f[0] &  line_d[0] & ~line_d[1] &  line_f[1];
    assign sda_s     =  line_f[1];

endmodule

// File: rtl/i2c_display_target.sv
// I2C write-only display target: decodes address/control/data stream into framebuffer writes and command strobes.
// Build option: `I2C_GLITCH_FILTER_EN enables the FILTER_LEN-sample glitch filter on SCL/SDA.
module i2c_display_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3,
    parameter int         FB_AW      = 10
) (
    input logic                 clk,
    input logic                 reset,
    i2c_display_target_if.slave bus
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_display_target_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e        state_q, state_n;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        shift_in;
    logic              co_q, dc_q;
    logic [PAGE_W-1:0] page_q;
    logic [COL_W-1:0]  col_q;

    logic              sda_oe_q, fb_wen_q, cmd_valid_q, busy_q;
    logic [FB_AW-1:0]  fb_waddr_q;
    logic [7:0]        fb_wdata_q, cmd_byte_q;

    logic              bit_en, byte_end, ctrl_done, byte_done, addr_hit, ack_n;
    cmd_dec_t          dec;

    assign shift_in = {shift_q[6:0], sda_s};
    assign byte_end = scl_fall && (bit_cnt_q == 4'd8);
    assign addr_hit = (shift_q[7:1] == TGT_ADDR) && !shift_q[0];
    assign dec      = decode_cmd(shift_in);
    assign ack_n    = (state_n == ADDR_ACK) || (state_n == CTRL_ACK) || (state_n == BYTE_ACK);

    // START/STOP take priority over any SCL edge seen in the same sample.
    always_comb begin
        state_n   = state_q;
        bit_en    = 1'b0;
        ctrl_done = 1'b0;
        byte_done = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
        end else if (start_det) begin
            state_n = ADDR;
        end else begin
            case (state_q)
                ADDR: begin
                    bit_en = scl_rise && (bit_cnt_q != 4'd8);
                    if (byte_end) state_n = addr_hit ? ADDR_ACK : IGNORE;
                end
                CTRL: begin
                    bit_en    = scl_rise && (bit_cnt_q != 4'd8);
                    ctrl_done = bit_en && (bit_cnt_q == 4'd7);
                    if (byte_end) state_n = CTRL_ACK;
                end
                BYTE: begin
                    bit_en    = scl_rise && (bit_cnt_q != 4'd8);
                    byte_done = bit_en && (bit_cnt_q == 4'd7);
                    if (byte_end) state_n = BYTE_ACK;
                end
                ADDR_ACK: if (scl_fall) state_n = CTRL;
                CTRL_ACK: if (scl_fall) state_n = BYTE;
                BYTE_ACK: if (scl_fall) state_n = co_q ? CTRL : BYTE;
                default:  state_n = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            co_q        <= 1'b0;
            dc_q        <= 1'b0;
            page_q      <= '0;
            col_q       <= '0;
            sda_oe_q    <= 1'b0;
            fb_wen_q    <= 1'b0;
            fb_waddr_q  <= '0;
            fb_wdata_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            sda_oe_q    <= ack_n;
            fb_wen_q    <= 1'b0;
            cmd_valid_q <= 1'b0;

            // Any state change (including START/STOP) starts a fresh bit count.
            if (start_det || stop_det || (state_n != state_q)) begin
                bit_cnt_q <= '0;
            end else if (bit_en) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                shift_q   <= shift_in;
            end

            if (stop_det)
                busy_q <= 1'b0;
            else if (state_q == ADDR && state_n == ADDR_ACK)
                busy_q <= 1'b1;
            else if (state_q == ADDR && state_n == IGNORE)
                busy_q <= 1'b0;

            if (ctrl_done) begin
                co_q <= shift_in[CTRL_CO_BIT];
                dc_q <= shift_in[CTRL_DC_BIT];
            end

            if (byte_done) begin
                if (dc_q) begin
                    fb_wen_q        <= 1'b1;
                    fb_waddr_q      <= FB_AW'({page_q, col_q});
                    fb_wdata_q      <= shift_in;
                    // Column carry rolls into the page; the whole pointer wraps at the end of GDDRAM.
                    {page_q, col_q} <= {page_q, col_q} + PTR_W'(1);
                end else begin
                    cmd_valid_q <= 1'b1;
                    cmd_byte_q  <= shift_in;
                    if (dec.set_page)   page_q     <= shift_in[2:0];
                    if (dec.set_col_lo) col_q[3:0] <= shift_in[3:0];
                    if (dec.set_col_hi) col_q[6:4] <= shift_in[2:0];
                end
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.fb_wen    = fb_wen_q;
    assign bus.fb_waddr  = fb_waddr_q;
    assign bus.fb_wdata  = fb_wdata_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_byte  = cmd_byte_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_display_target.sv
// Directed bench for i2c_display_target: bit-banged I2C writes, strobe log, immediate-assertion checks.
module tb_i2c_display_target;
    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_display_target_if #(.FB_AW(10)) bus ();

    // Open-drain wiring: either side can pull SDA low.
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_display_target #(
        .TGT_ADDR   (7'h3C),
        .FILTER_LEN (3),
        .FB_AW      (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [17:0] fb_log  [0:63];
    logic [7:0]  cmd_log [0:63];
    int fb_n = 0, cmd_n = 0, oe_n = 0, busy_n = 0;

    always @(negedge clk) begin
        if (bus.fb_wen && fb_n < 64) begin
            fb_log[fb_n] <= {bus.fb_waddr, bus.fb_wdata};
            fb_n <= fb_n + 1;
        end
        if (bus.cmd_valid && cmd_n < 64) begin
            cmd_log[cmd_n] <= bus.cmd_byte;
            cmd_n <= cmd_n + 1;
        end
        if (bus.sda_oe) oe_n <= oe_n + 1;
        if (bus.busy)   busy_n <= busy_n + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; wclk(Q);
        m_sda = 1'b0; wclk(2 * Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b1; wclk(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        if (glitch) begin
            m_scl = 1'b0; wclk(1);
            m_scl = 1'b1;
        end
        wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    // ack = SDA level seen during the 9th clock (0 means the target ACKed).
    task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit);
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        ack = bus.sda_in;
        wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    // Sends n bytes, first byte in v[8*n-1 -: 8]; acks[i] = 1 when byte i (counted from the end) was ACKed.
    task automatic xfer(input int n, input logic [63:0] v, output logic [7:0] acks);
        logic a;
        acks = '0;
        i2c_start();
        for (int i = n - 1; i >= 0; i--) begin
            send_byte(v[8*i +: 8], -1, a);
            acks[i] = ~a;
        end
        i2c_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] acks;
        int         fb0, cmd0, oe0, busy0;

        // Reset state
        wclk(3);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_fb_wen", 32'(bus.fb_wen), 32'd0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        wclk(4);

        // 1: data write at {0,0} and {0,1}
        i2c_start();
        send_byte(8'h78, -1, a); chk("t1_ack_addr", 32'(a), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h40, -1, a); chk("t1_ack_ctrl", 32'(a), 32'd0);
        send_byte(8'hAA, -1, a); chk("t1_ack_d0", 32'(a), 32'd0);
        send_byte(8'h55, -1, a); chk("t1_ack_d1", 32'(a), 32'd0);
        i2c_stop();
        wclk(4);
        chk("t1_busy_after_stop", 32'(bus.busy), 32'd0);
        chk("t1_fb_count", 32'(fb_n), 32'd2);
        chk("t1_fb0", 32'(fb_log[0]), 32'h000AA);
        chk("t1_fb1", 32'(fb_log[1]), 32'h00155);

        // 2: page/column commands then a data byte at page 3, col 0x25
        xfer(5, 64'h78_00_B3_05_12, acks);
        chk("t2_cmd_acks", 32'(acks), 32'h1F);
        chk("t2_cmd_count", 32'(cmd_n), 32'd3);
        chk("t2_cmd0", 32'(cmd_log[0]), 32'hB3);
        chk("t2_cmd1", 32'(cmd_log[1]), 32'h05);
        chk("t2_cmd2", 32'(cmd_log[2]), 32'h12);
        xfer(3, 64'h78_40_FF, acks);
        chk("t2_data_acks", 32'(acks), 32'h07);
        chk("t2_fb", 32'(fb_log[2]), 32'h1A5FF);

        // 3: wrong address, then a read to our address -> silent
        fb0 = fb_n; cmd0 = cmd_n; oe0 = oe_n; busy0 = busy_n;
        xfer(3, 64'h7A_40_AA, acks);
        chk("t3_wrong_addr_acks", 32'(acks), 32'h00);
        xfer(2, 64'h79_40, acks);
        chk("t3_read_acks", 32'(acks), 32'h00);
        wclk(4);
        chk("t3_no_oe", 32'(oe_n - oe0), 32'd0);
        chk("t3_no_fb", 32'(fb_n - fb0), 32'd0);
        chk("t3_no_cmd", 32'(cmd_n - cmd0), 32'd0);
        chk("t3_no_busy", 32'(busy_n - busy0), 32'd0);

        // 4: pointer wrap from page 7 col 127
        xfer(5, 64'h78_00_B7_0F_17, acks);
        chk("t4_cmd_acks", 32'(acks), 32'h1F);
        xfer(4, 64'h78_40_11_22, acks);
        chk("t4_data_acks", 32'(acks), 32'h0F);
        chk("t4_fb_last", 32'(fb_log[3]), 32'h3FF11);
        chk("t4_fb_wrap", 32'(fb_log[4]), 32'h00022);

        // 5a: STOP after 4 data bits discards the partial byte
        fb0 = fb_n;
        i2c_start();
        send_byte(8'h78, -1, a);
        send_byte(8'h40, -1, a);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        i2c_stop();
        wclk(4);
        chk("t5_partial_no_fb", 32'(fb_n - fb0), 32'd0);

        // 5b: reset pulse during the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i[0] == 1'b0 ? (i >= 3 && i <= 6) : (i >= 3 && i <= 6), 1'b0);
        m_sda = 1'b1; wclk(Q);
        chk("t5_oe_in_ack", 32'(bus.sda_oe), 32'd1);
        reset = 1'b0; wclk(1);
        chk("t5_oe_after_rst", 32'(bus.sda_oe), 32'd0);
        chk("t5_busy_after_rst", 32'(bus.busy), 32'd0);
        reset = 1'b1; wclk(2);
        m_scl = 1'b1; wclk(2 * Q);
        xfer(3, 64'h78_40_5A, acks);
        chk("t5_clean_acks", 32'(acks), 32'h07);
        chk("t5_clean_fb", 32'(fb_log[fb_n - 1]), 32'h0005A);

`ifdef I2C_GLITCH_FILTER_EN
        // 6: 1-clk SCL low glitch while SCL is high is filtered out
        i2c_start();
        send_byte(8'h78, -1, a);
        send_byte(8'h40, -1, a);
        send_byte(8'hC3, 4, a);
        chk("t6_glitch_ack", 32'(a), 32'd0);
        i2c_stop();
        wclk(4);
        chk("t6_glitch_fb", 32'(fb_log[fb_n - 1]), 32'h001C3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
